// File: rtl/stream_fifo_pkg.sv
// Shared definitions for the stream FIFO: depth limit and the parameter
// legality check used at elaboration.
package stream_fifo_pkg;

  localparam int STREAM_MAX_DEPTH_LOG2 = 8;

  function automatic bit stream_params_ok(int width, int depth_log2);
    return (width > 0) && (depth_log2 >= 1) && (depth_log2 <= STREAM_MAX_DEPTH_LOG2);
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides. Flags and
// level come from the registered pointers only, so there are no
// combinational paths from s_valid_i or m_ready_i.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [WIDTH-1:0]      data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  generate
    if (!stream_params_ok(WIDTH, DEPTH_LOG2)) begin : g_param_err
      $error("stream_fifo: illegal WIDTH=%0d or DEPTH_LOG2=%0d", WIDTH, DEPTH_LOG2);
    end
  endgenerate

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [WIDTH-1:0]      last_q, last_d;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
  logic                  full, empty, push, pop;

  assign wr_idx = wr_ptr_q[DEPTH_LOG2-1:0];
  assign rd_idx = rd_ptr_q[DEPTH_LOG2-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {DEPTH_LOG2{1'b0}}});
  assign push   = s_valid_i && !full;
  assign pop    = m_ready_i && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    if (push) begin
      mem_d[wr_idx] = s_data_i;
      wr_ptr_d      = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      last_d   = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
      mem_q    <= mem_d;
    end
  end

  // When drained, the head slot may hold stale data from an earlier lap,
  // so the last popped word is presented instead.
  assign data_o    = empty ? last_q : mem_q[rd_idx];
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign full_o    = full;
  assign empty_o   = empty;
  assign s_ready_o = !full;
  assign m_valid_o = !empty;

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: directed phases plus random traffic, checked every
// cycle against a queue-based model of the FIFO.
module tb_stream_fifo;

  localparam int WIDTH = 8;
  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;

  logic             clk = 0;
  logic             rst;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] data;
  logic             m_valid;
  logic             m_ready;
  logic [DL2:0]     level;
  logic             full;
  logic             empty;

  stream_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DL2)) dut (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(s_valid),
    .s_ready_o(s_ready), .data_o(data), .m_valid_o(m_valid),
    .m_ready_i(m_ready), .level_o(level), .full_o(full), .empty_o(empty)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] model_last;
  logic [WIDTH-1:0] got_q[$];
  bit               model_pushed;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_model();
    int sz = model_q.size();
    chk("level", 32'(level), 32'(sz));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("s_ready", 32'(s_ready), 32'(sz != DEPTH));
    chk("m_valid", 32'(m_valid), 32'(sz != 0));
    chk("data", 32'(data), 32'(sz != 0 ? model_q[0] : model_last));
  endtask

  // One clock: drive inputs, record the DUT handshake, advance the model,
  // then check all outputs at the following falling edge.
  task automatic cyc(input logic sv, input logic [WIDTH-1:0] sd,
                     input logic mr, input logic rs);
    bit do_push, do_pop;
    s_valid = sv; s_data = sd; m_ready = mr; rst = rs;
    #1;
    if (!rs && m_valid === 1'b1 && mr) got_q.push_back(data);
    do_push = !rs && sv && (model_q.size() < DEPTH);
    do_pop  = !rs && mr && (model_q.size() > 0);
    @(posedge clk);
    if (rs) begin
      model_q.delete();
      model_last = '0;
    end else begin
      if (do_pop) model_last = model_q.pop_front();
      if (do_push) model_q.push_back(sd);
    end
    model_pushed = do_push;
    @(negedge clk);
    chk_model();
  endtask

  initial begin
    int k;
    model_last = '0;
    s_valid = 0; s_data = 0; m_ready = 0; rst = 1;
    @(negedge clk);

    // reset held two cycles with a write request pending
    cyc(1, 8'hEE, 0, 1);
    chk("rst_data", 32'(data), 32'h0);
    cyc(1, 8'hEE, 0, 1);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_ready", 32'(s_ready), 32'h1);

    // fill to full, reject a fifth word, then drain in order
    cyc(1, 8'h11, 0, 0);
    chk("fwft_data", 32'(data), 32'h11);
    cyc(1, 8'h22, 0, 0);
    cyc(1, 8'h33, 0, 0);
    cyc(1, 8'h44, 0, 0);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_level", 32'(level), 32'h4);
    chk("fill_ready", 32'(s_ready), 32'h0);
    cyc(1, 8'h55, 0, 0);
    chk("fifth_level", 32'(level), 32'h4);
    chk("pop0", 32'(data), 32'h11);
    cyc(0, 8'h00, 1, 0);
    chk("pop1", 32'(data), 32'h22);
    cyc(0, 8'h00, 1, 0);
    chk("pop2", 32'(data), 32'h33);
    cyc(0, 8'h00, 1, 0);
    chk("pop3", 32'(data), 32'h44);
    cyc(0, 8'h00, 1, 0);
    chk("drain_empty", 32'(empty), 32'h1);
    chk("drain_last", 32'(data), 32'h44);

    // simultaneous push/pop at level 2
    cyc(1, 8'hA0, 0, 0);
    cyc(1, 8'hA1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 8'(8'hB0 + i), 1, 0);
      chk("simul_level", 32'(level), 32'h2);
    end
    while (model_q.size() > 0) cyc(0, 8'h00, 1, 0);

    // pointer wrap: 20 incrementing words, consumer toggling
    got_q.delete();
    k = 0;
    for (int t = 0; t < 200 && got_q.size() < 20; t++) begin
      cyc(k < 20, 8'(k + 1), t[0], 0);
      if (model_pushed) k++;
      chk("wrap_level_max", 32'(level <= 3'd4), 32'h1);
    end
    chk("wrap_count", 32'(got_q.size()), 32'd20);
    for (int i = 0; i < got_q.size() && i < 20; i++)
      chk("wrap_order", 32'(got_q[i]), 32'(i + 1));

    // full with pop and push requested together
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
    chk("fp_full", 32'(full), 32'h1);
    cyc(1, 8'h66, 1, 0);
    chk("fp_level", 32'(level), 32'h3);
    chk("fp_ready", 32'(s_ready), 32'h1);
    chk("fp_head", 32'(data), 32'hC1);

    // reset mid-burst at level 3
    cyc(1, 8'h77, 1, 1);
    chk("mid_rst_level", 32'(level), 32'h0);
    chk("mid_rst_valid", 32'(m_valid), 32'h0);
    cyc(1, 8'hA5, 0, 0);
    chk("post_rst_first", 32'(data), 32'hA5);
    cyc(0, 8'h00, 1, 0);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
          $urandom_range(0, 49) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
